// File: rtl/text_screen_gen_if.sv
// Bus between the VGA character-position logic and the text overlay generator.
// The master side drives frame timing, message selection, BCD fields and the
// character position; the slave side returns the character code for the font ROM.
interface text_screen_gen_if #(
    parameter int XW = 5,
    parameter int YW = 5
);
    logic                 frame_tick;
    logic                 restart;
    logic [1:0]           msg_sel;
    logic [7:0]           pairs_bcd;
    logic [7:0]           sec_bcd;
    logic [7:0]           hsec_bcd;
    logic [YW+XW-1:0]     char_yx;
    logic [6:0]           char_code;
    logic                 reveal_done;

    modport master (
        output frame_tick, restart, msg_sel, pairs_bcd, sec_bcd, hsec_bcd, char_yx,
        input  char_code, reveal_done
    );

    modport slave (
        input  frame_tick, restart, msg_sel, pairs_bcd, sec_bcd, hsec_bcd, char_yx,
        output char_code, reveal_done
    );
endinterface

// File: rtl/text_screen_gen.sv
// Text overlay character-code generator for the end-of-game and title screens.
// Maps {char_y,char_x} to a 7-bit ASCII code (0 = blank) with a typewriter
// reveal paced by frame ticks. Numeric fields are sampled once per frame so
// they never tear mid-frame.
// Optional feature: define CURSOR_BLINK_EN to show a blinking '_' cursor at
// the next position to be revealed.
module text_screen_gen #(
    parameter int COLS       = 17,
    parameter int ROWS       = 5,
    parameter int XW         = 5,
    parameter int YW         = 5,
    parameter int REVEAL_DIV = 4
) (
    input logic              clk,
    input logic              rst,
    text_screen_gen_if.slave scr_if
);

    localparam int TOTAL = COLS * ROWS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int DIVW  = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(REVEAL_DIV - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TOTAL - 1);

    localparam logic [1:0] MSG_WIN       = 2'd0;
    localparam logic [1:0] MSG_GAME_OVER = 2'd1;
    localparam logic [1:0] MSG_TITLE     = 2'd2;

    localparam logic [135:0] WIN_R0   = " Congratulation! ";
    localparam logic [135:0] WIN_R2   = " Your score: 00PP";
    localparam logic [135:0] WIN_R4   = " Your time: SS.HH";
    localparam logic [135:0] OVER_R0  = "   GAME OVER!    ";
    localparam logic [135:0] OVER_R2  = " Your score: 0000";
    localparam logic [135:0] OVER_R4  = " Your time passed";
    localparam logic [135:0] TITLE_R0 = "  MEMORY  GAME   ";
    localparam logic [135:0] TITLE_R2 = "  Press to start ";

    typedef enum logic {
        ST_REVEAL = 1'b0,
        ST_DONE   = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DIVW-1:0] div_q;
    logic [1:0]      msg_q;
    logic [7:0]      pairs_q;
    logic [7:0]      sec_q;
    logic [7:0]      hsec_q;
    logic [6:0]      charCode_q;
    logic [6:0]      charCode_d;
    logic            revealDone_q;

    logic            restartReq;
    logic            cursorOn;
    logic [XW-1:0]   charX;
    logic [YW-1:0]   charY;
    logic [15:0]     posX;
    logic [15:0]     posY;
    logic [15:0]     idx;
    logic [15:0]     cntWide;
    logic            inRange;
    logic [135:0]    textLine;
    logic [6:0]      textCode;

    // Picks column col (0..16) of a 17-character line; spaces become blank.
    function automatic logic [6:0] pickChar(input logic [135:0] line, input logic [4:0] col);
        logic [7:0] ch;
        ch = line[{5'd16 - col, 3'b000} +: 8];
        return (ch == 8'd32) ? 7'd0 : ch[6:0];
    endfunction

    // BCD digit to ASCII; an invalid nibble shows as '?'.
    function automatic logic [6:0] digitChar(input logic [3:0] n);
        return (n > 4'd9) ? 7'd63 : (7'd48 + {3'b000, n});
    endfunction

    assign restartReq = scr_if.restart | (scr_if.msg_sel != msg_q);

    assign charX   = scr_if.char_yx[XW-1:0];
    assign charY   = scr_if.char_yx[XW+YW-1:XW];
    assign posX    = 16'(charX);
    assign posY    = 16'(charY);
    assign idx     = posY * 16'(COLS) + posX;
    assign cntWide = 16'(cnt_q);
    assign inRange = (posX < 16'(COLS)) && (posY < 16'(ROWS));

    // Message copy for change detection, and once-per-frame capture of the numeric fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_q   <= 2'd0;
            pairs_q <= 8'd0;
            sec_q   <= 8'd0;
            hsec_q  <= 8'd0;
        end else begin
            msg_q <= scr_if.msg_sel;
            if (scr_if.frame_tick) begin
                pairs_q <= scr_if.pairs_bcd;
                sec_q   <= scr_if.sec_bcd;
                hsec_q  <= scr_if.hsec_bcd;
            end
        end
    end

    // Reveal FSM: a restart request outranks a same-cycle frame tick, which is then not counted.
    always_ff @(posedge clk) begin
        if (rst || restartReq) begin
            state_q      <= ST_REVEAL;
            cnt_q        <= '0;
            div_q        <= '0;
            revealDone_q <= 1'b0;
        end else begin
            case (state_q)
                ST_REVEAL: begin
                    if (scr_if.frame_tick) begin
                        if (div_q == DIV_LAST) begin
                            div_q <= '0;
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CNT_LAST) begin
                                state_q      <= ST_DONE;
                                revealDone_q <= 1'b1;
                            end
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    revealDone_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_REVEAL;
                end
            endcase
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [2:0] blinkCnt_q;
    logic       blink_q;

    // Cursor blink phase flips after every eighth frame tick since the last restart.
    always_ff @(posedge clk) begin
        if (rst || restartReq) begin
            blinkCnt_q <= 3'd0;
            blink_q    <= 1'b0;
        end else if (scr_if.frame_tick) begin
            blinkCnt_q <= blinkCnt_q + 3'd1;
            if (blinkCnt_q == 3'd7) begin
                blink_q <= ~blink_q;
            end
        end
    end

    assign cursorOn = blink_q && (state_q == ST_REVEAL);
`else
    assign cursorOn = 1'b0;
`endif

    // Layout lookup: fixed line text with the live digit fields of the WIN screen overlaid.
    always_comb begin
        textLine = '0;
        textCode = 7'd0;
        if ((posX <= 16'd16) && (posY <= 16'd4) && !posY[0]) begin
            case (msg_q)
                MSG_WIN: begin
                    case (posY[2:0])
                        3'd0:    textLine = WIN_R0;
                        3'd2:    textLine = WIN_R2;
                        3'd4:    textLine = WIN_R4;
                        default: textLine = '0;
                    endcase
                end
                MSG_GAME_OVER: begin
                    case (posY[2:0])
                        3'd0:    textLine = OVER_R0;
                        3'd2:    textLine = OVER_R2;
                        3'd4:    textLine = OVER_R4;
                        default: textLine = '0;
                    endcase
                end
                MSG_TITLE: begin
                    case (posY[2:0])
                        3'd0:    textLine = TITLE_R0;
                        3'd2:    textLine = TITLE_R2;
                        default: textLine = '0;
                    endcase
                end
                default: textLine = '0;
            endcase
            textCode = pickChar(textLine, posX[4:0]);
            if (msg_q == MSG_WIN && posY[2:0] == 3'd2) begin
                if (posX[4:0] == 5'd15) textCode = digitChar(pairs_q[7:4]);
                if (posX[4:0] == 5'd16) textCode = digitChar(pairs_q[3:0]);
            end
            if (msg_q == MSG_WIN && posY[2:0] == 3'd4) begin
                case (posX[4:0])
                    5'd12:   textCode = digitChar(sec_q[7:4]);
                    5'd13:   textCode = digitChar(sec_q[3:0]);
                    5'd15:   textCode = digitChar(hsec_q[7:4]);
                    5'd16:   textCode = digitChar(hsec_q[3:0]);
                    default: textCode = textCode;
                endcase
            end
        end
    end

    // Reveal masking: only already-revealed positions show text; the cursor sits just past them.
    always_comb begin
        charCode_d = 7'd0;
        if (inRange) begin
            if (idx < cntWide) begin
                charCode_d = textCode;
            end else if ((idx == cntWide) && cursorOn) begin
                charCode_d = 7'd95;
            end
        end
    end

    // Registered character code, one clock behind char_yx.
    always_ff @(posedge clk) begin
        if (rst) begin
            charCode_q <= 7'd0;
        end else begin
            charCode_q <= charCode_d;
        end
    end

    assign scr_if.char_code   = charCode_q;
    assign scr_if.reveal_done = revealDone_q;

endmodule

// File: tb/tb_text_screen_gen.sv
// Randomized self-checking bench for text_screen_gen. The reference model
// builds each screen line as a string from the layout rules and derives the
// number of revealed characters from the count of frame ticks since restart.
module tb_text_screen_gen;

   localparam int COLS       = 17;
   localparam int ROWS       = 5;
   localparam int XW         = 5;
   localparam int YW         = 5;
   localparam int REVEAL_DIV = 2;
   localparam int TOTAL      = COLS * ROWS;

   logic clk = 1'b0;
   logic rst;

   int checkCount = 0;
   int failCount  = 0;

   int         mTicks;
   logic [1:0] mMsg;
   logic [7:0] mPairs;
   logic [7:0] mSec;
   logic [7:0] mHsec;

   text_screen_gen_if #(.XW(XW), .YW(YW)) scr ();

   text_screen_gen #(
      .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .REVEAL_DIV(REVEAL_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .scr_if(scr)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic string dig(input logic [3:0] n);
      if (n > 4'd9) return "?";
      return $sformatf("%0d", n);
   endfunction

   // Full text of one screen line for the model's current message and shadows
   function automatic string rowText(input logic [1:0] msg, input int y);
      case (msg)
         2'd0: begin
            if (y == 0) return " Congratulation! ";
            if (y == 2) return {" Your score: 00", dig(mPairs[7:4]), dig(mPairs[3:0])};
            if (y == 4) return {" Your time: ", dig(mSec[7:4]), dig(mSec[3:0]), ".",
                                dig(mHsec[7:4]), dig(mHsec[3:0])};
         end
         2'd1: begin
            if (y == 0) return "   GAME OVER!    ";
            if (y == 2) return " Your score: 0000";
            if (y == 4) return " Your time passed";
         end
         2'd2: begin
            if (y == 0) return "  MEMORY  GAME   ";
            if (y == 2) return "  Press to start ";
         end
         default: return "";
      endcase
      return "";
   endfunction

   function automatic int shownCount();
      int s;
      s = mTicks / REVEAL_DIV;
      return (s > TOTAL) ? TOTAL : s;
   endfunction

   function automatic logic [6:0] modelChar(input logic [9:0] yx);
      int    x, y, idx, shown;
      string s;
      byte   c;
      x = int'(yx[4:0]);
      y = int'(yx[9:5]);
      if (x >= COLS || y >= ROWS) return 7'd0;
      idx   = y * COLS + x;
      shown = shownCount();
      if (idx >= shown) begin
`ifdef CURSOR_BLINK_EN
         if (idx == shown && shown < TOTAL && ((mTicks / 8) % 2 == 1)) return 7'd95;
`endif
         return 7'd0;
      end
      s = rowText(mMsg, y);
      if (x >= s.len()) return 7'd0;
      c = s[x];
      if (c == 8'd32) return 7'd0;
      return c[6:0];
   endfunction

   function automatic logic [9:0] randYx();
      if ($urandom_range(0, 3) != 0)
         return {5'($urandom_range(0, ROWS - 1)), 5'($urandom_range(0, COLS - 1))};
      return 10'($urandom);
   endfunction

   // One clock: drive inputs, advance the model across the edge, compare outputs
   task automatic applyStimulus(input logic tick, input logic rs, input logic [9:0] yx);
      logic [6:0] expChar;
      scr.frame_tick = tick;
      scr.restart    = rs;
      scr.char_yx    = yx;
      expChar = rst ? 7'd0 : modelChar(yx);
      @(posedge clk);
      #1;
      if (rst) begin
         mTicks = 0; mMsg = 2'd0; mPairs = 8'd0; mSec = 8'd0; mHsec = 8'd0;
      end else begin
         if (tick) begin
            mPairs = scr.pairs_bcd;
            mSec   = scr.sec_bcd;
            mHsec  = scr.hsec_bcd;
         end
         if (rs || scr.msg_sel != mMsg) begin
            mTicks = 0;
            mMsg   = scr.msg_sel;
         end else if (tick) begin
            mTicks++;
         end
      end
      checkOutput($sformatf("char_code@%03h", yx), 32'(scr.char_code), 32'(expChar));
      checkOutput("reveal_done", 32'(scr.reveal_done), 32'(shownCount() == TOTAL));
      scr.frame_tick = 1'b0;
      scr.restart    = 1'b0;
   endtask

   task automatic randomBcd();
      scr.pairs_bcd = 8'($urandom);
      scr.sec_bcd   = 8'($urandom);
      scr.hsec_bcd  = 8'($urandom);
   endtask

   initial begin
      int msgs[5] = '{0, 1, 2, 3, 0};
      rst            = 1'b1;
      scr.frame_tick = 1'b0;
      scr.restart    = 1'b0;
      scr.msg_sel    = 2'd0;
      scr.pairs_bcd  = 8'h00;
      scr.sec_bcd    = 8'h00;
      scr.hsec_bcd   = 8'h00;
      scr.char_yx    = '0;
      mTicks = 0; mMsg = 2'd0; mPairs = 8'd0; mSec = 8'd0; mHsec = 8'd0;

      $display("[TB] reset");
      applyStimulus(1'b0, 1'b0, 10'h001);
      applyStimulus(1'b1, 1'b0, 10'h002);
      rst = 1'b0;

      // Full reveal of each message, with the numeric inputs changing mid-frame
      foreach (msgs[p]) begin
         $display("[TB] reveal phase msg=%0d", msgs[p]);
         scr.msg_sel = 2'(msgs[p]);
         for (int c = 0; c < (TOTAL * REVEAL_DIV + 8) * 3; c++) begin
            if ($urandom_range(0, 4) == 0) randomBcd();
            applyStimulus(1'b1 && (c % 3 == 2), 1'b0, randYx());
         end
         for (int y = 0; y < 7; y++)
            for (int x = 0; x < 20; x++)
               applyStimulus(1'b0, 1'b0, {5'(y), 5'(x)});
      end

      // Restarts (some coinciding with frame ticks), message changes and a mid-reveal reset
      $display("[TB] restart phase");
      for (int c = 0; c < 1500; c++) begin
         logic tick, rs;
         if ($urandom_range(0, 4) == 0) randomBcd();
         if ($urandom_range(0, 299) == 0) scr.msg_sel = 2'($urandom);
         tick = ($urandom_range(0, 2) == 0);
         rs   = ($urandom_range(0, 79) == 0) || (c % 397 == 200);
         if (c % 397 == 200) tick = 1'b1;
         if (c == 700) rst = 1'b1;
         applyStimulus(tick, rs, randYx());
         rst = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
